// File: rtl/wb_scoreboard.sv
// Register write-back scoreboard: per-register pending-write counters with RAW/WAW-max issue stall.
// Optional macro WB_SCOREBOARD_BYPASS_EN frees a source register in its final write-back cycle.
module wb_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_use_rt,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_nd,
  output logic            issue_ready,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_nd,
  output logic [NREG-1:0] busy_vec,
  output logic            overflow_err,
  output logic            underflow_err
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [CNT_W-1:0] w_cnt [NREG];
  logic             w_rs_byp;
  logic             w_rt_byp;
  logic             w_rs_busy;
  logic             w_rt_busy;
  logic             w_nd_full;
  logic             w_haz;
  logic             w_accept;
  logic             w_inc_any;
  logic             w_dec_any;
  logic             w_same_reg;
  logic             r_ovf;
  logic             r_unf;

`ifdef WB_SCOREBOARD_BYPASS_EN
  // Last outstanding write landing this cycle is visible through the register-file bypass.
  assign w_rs_byp = wb_valid && (wb_nd == issue_rs) && (w_cnt[issue_rs] == CONE);
  assign w_rt_byp = wb_valid && (wb_nd == issue_rt) && (w_cnt[issue_rt] == CONE);
`else
  assign w_rs_byp = 1'b0;
  assign w_rt_byp = 1'b0;
`endif

  assign w_rs_busy = (w_cnt[issue_rs] != '0) && !w_rs_byp;
  assign w_rt_busy = (w_cnt[issue_rt] != '0) && !w_rt_byp;
  assign w_nd_full = issue_we && (issue_nd != '0) && (w_cnt[issue_nd] == CMAX);
  assign w_haz     = issue_valid && (w_rs_busy || (issue_use_rt && w_rt_busy) || w_nd_full);

  assign stall       = w_haz;
  assign issue_ready = !w_haz;
  assign w_accept    = issue_valid && issue_ready;

  assign w_inc_any  = w_accept && issue_we && (issue_nd != '0);
  assign w_dec_any  = wb_valid && (wb_nd != '0);
  assign w_same_reg = w_inc_any && w_dec_any && (issue_nd == wb_nd);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_cnt[gi] = '0;
    end else begin : g_cnt
      logic r_cnt_q;
      logic [CNT_W-1:0] r_cnt;
      logic w_inc;
      logic w_dec;
      assign w_inc = w_inc_any && (issue_nd == AW'(gi));
      assign w_dec = w_dec_any && (wb_nd == AW'(gi));
      // Coincident issue and write-back to the same register cancel out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          if (r_cnt != CMAX) r_cnt <= r_cnt + CONE;
        end else if (w_dec && !w_inc) begin
          if (r_cnt != '0) r_cnt <= r_cnt - CONE;
        end
      end
      assign r_cnt_q   = 1'b0;
      assign w_cnt[gi] = r_cnt;
    end
    assign busy_vec[gi] = (w_cnt[gi] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_inc_any && !w_same_reg && (w_cnt[issue_nd] == CMAX)) r_ovf <= 1'b1;
      if (w_dec_any && !w_same_reg && (w_cnt[wb_nd] == '0))      r_unf <= 1'b1;
    end
  end

  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed steps plus random traffic against a count-per-register model.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_use_rt, issue_we, wb_valid;
  logic [4:0]  issue_rs, issue_rt, issue_nd, wb_nd;
  logic        issue_ready, stall, overflow_err, underflow_err;
  logic [31:0] busy_vec;

  int checks = 0;
  int failures = 0;
  int m_cnt [32];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  wb_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rt(issue_use_rt), .issue_we(issue_we), .issue_nd(issue_nd),
    .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_nd(wb_nd), .busy_vec(busy_vec),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  function automatic bit src_blocked(input int r);
    bit byp;
    byp = 0;
`ifdef WB_SCOREBOARD_BYPASS_EN
    byp = wb_valid && (int'(wb_nd) == r) && (m_cnt[r] == 1);
`endif
    return (m_cnt[r] > 0) && !byp;
  endfunction

  function automatic bit model_haz();
    if (!issue_valid) return 0;
    return src_blocked(int'(issue_rs)) || (issue_use_rt && src_blocked(int'(issue_rt))) ||
           (issue_we && issue_nd != 0 && m_cnt[issue_nd] == 3);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_busy"}, busy_vec, model_busy());
    check({tag, "_ovf"}, 32'(overflow_err), 32'(m_ovf));
    check({tag, "_unf"}, 32'(underflow_err), 32'(m_unf));
  endtask

  // One clock: apply inputs, check combinational outputs, then check updated state.
  task automatic drive(input string tag, input bit iv, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urt, input bit we, input logic [4:0] nd,
                       input bit wv, input logic [4:0] wnd);
    bit haz;
    int inc, dec;
    issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_use_rt = urt;
    issue_we = we; issue_nd = nd; wb_valid = wv; wb_nd = wnd;
    #2;
    haz = model_haz();
    check({tag, "_stall"}, 32'(stall), 32'(haz));
    check({tag, "_ready"}, 32'(issue_ready), 32'(!haz));
    inc = (iv && !haz && we && nd != 0) ? int'(nd) : -1;
    dec = (wv && wnd != 0) ? int'(wnd) : -1;
    @(posedge clk);
    if (inc != dec) begin
      if (inc > 0) begin
        if (m_cnt[inc] == 3) m_ovf = 1; else m_cnt[inc]++;
      end
      if (dec > 0) begin
        if (m_cnt[dec] == 0) m_unf = 1; else m_cnt[dec]--;
      end
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    logic [4:0] pick;
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rt = 0;
    issue_we = 0; issue_nd = 0; wb_valid = 0; wb_nd = 0;
    rst_n = 0;
    model_reset();
    #1;
    check_state("reset");
    check("reset_ready", 32'(issue_ready), 32'd1);
    #11 rst_n = 1;

    drive("tp1", 1, 5'd3, 5'd4, 1, 1, 5'd5, 0, 5'd0);
    check("tp1_busy20", busy_vec, 32'h20);

    drive("raw_stall", 1, 5'd5, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("raw_stall_const", 32'(stall), 32'd1);
    drive("raw_wb", 1, 5'd5, 5'd0, 0, 0, 5'd0, 1, 5'd5);
    drive("raw_clear", 1, 5'd5, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    check("raw_clear_const", 32'(stall), 32'd0);

    for (int k = 0; k < 3; k++) drive("waw_inc", 1, 5'd0, 5'd0, 0, 1, 5'd7, 0, 5'd0);
    drive("waw_max", 1, 5'd0, 5'd0, 0, 1, 5'd7, 0, 5'd0);
    for (int k = 0; k < 3; k++) drive("waw_wb", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd7);
    check("waw_free", 32'(busy_vec[7]), 32'd0);

    drive("same_reg", 1, 5'd0, 5'd0, 0, 1, 5'd9, 1, 5'd9);
    check("same_reg_unf", 32'(underflow_err), 32'd0);

    drive("unf_set", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd12);
    check("unf_set_const", 32'(underflow_err), 32'd1);
    drive("reg0", 1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 5'd0);
    check("reg0_unf_sticky", 32'(underflow_err), 32'd1);

    rst_n = 0;
    #1 model_reset();
    #10 rst_n = 1;
    drive("pre_rst_a", 1, 5'd0, 5'd0, 0, 1, 5'd2, 0, 5'd0);
    drive("pre_rst_b", 1, 5'd0, 5'd0, 0, 1, 5'd2, 0, 5'd0);
    #3 rst_n = 0;
    #1;
    model_reset();
    check("async_rst_busy", busy_vec, 32'h0);
    #2 rst_n = 1;
    drive("post_rst_wb", 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd2);
    check("post_rst_unf", 32'(underflow_err), 32'd1);

    rst_n = 0;
    #1 model_reset();
    #10 rst_n = 1;
    for (int n = 0; n < 600; n++) begin
      pick = 5'($urandom_range(0, 7));
      for (int t = 0; t < 8 && m_cnt[pick] == 0; t++) pick = 5'($urandom_range(0, 7));
      drive("rand", ($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
            ($urandom % 3) == 0, pick);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Tracks in-flight register writes for the multicycle/pipelined CPU datapath.
- Consumes the write-destination number ND on issue and the same ND on write-back.
- Checks the source registers (rs, rt) of each issuing instruction against pending writes and stalls issue on a RAW hazard.
- Sits between decode/issue and register-file write-back; it is the read side of the destination-select path.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register-number width; NREG must equal 2**AW.
- CNT_W, 2, per-register pending-write counter width; max outstanding writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  an instruction is presented for issue.
- issue_rs  in  AW  first source register.
- issue_rt  in  AW  second source register.
- issue_use_rt  in  1  rt is a true source (0 for immediate forms that write rt).
- issue_we  in  1  instruction writes a register.
- issue_nd  in  AW  destination register (already rt/rd-selected).
- issue_ready  out  1  issue accepted this cycle when issue_valid=1.
- stall  out  1  issue_valid=1 and a hazard blocks issue.
- wb_valid  in  1  a write-back completes this cycle.
- wb_nd  in  AW  register being written back.
- busy_vec  out  NREG  bit i=1 when register i has pending writes.
- overflow_err  out  1  sticky: issue attempted past counter max (never set when stall logic is obeyed).
- underflow_err  out  1  sticky: write-back to a register with zero pending writes.

Behaviour:
- Reset (rst_n=0, async): all counters 0, busy_vec=0, overflow_err=0, underflow_err=0.
- Reset mid-operation discards all pending state; write-backs for pre-reset issues are not tolerated: each sets underflow_err if its count is 0.
- State: cnt[i], CNT_W bits, for i=1..NREG-1; cnt[0] is constant 0.
- Hazard (combinational, from registered cnt): haz = issue_valid & ( cnt[rs]!=0 | (issue_use_rt & cnt[rt]!=0) | (issue_we & nd!=0 & cnt[nd]==max) ).
- Register 0 never hazards.
- Outputs: stall = haz; issue_ready = ~haz (1 when idle); busy_vec[i] = (cnt[i]!=0); busy_vec[0]=0.
- Issue accept = issue_valid & issue_ready. On accept with issue_we=1 and nd!=0: cnt[nd] += 1 at the next edge.
- WAW is permitted: a second write to a busy register increments its count; no stall unless the count is at max.
- Write-back: wb_valid=1, wb_nd!=0, cnt[wb_nd]!=0 -> cnt[wb_nd] -= 1.
- Write-back with cnt[wb_nd]==0 -> no change, underflow_err<=1.
- wb_nd=0 is ignored.
- Simultaneous accept-increment and write-back to the same register: net count unchanged, no error even if cnt==0 before the edge.
- Simultaneous events to different registers are independent.
- Single-cycle latency: a write-back at edge N clears a hazard visible in cycle N+1 (without bypass).
- overflow_err is set if the increment would wrap. Unreachable through the stall path; it guards direct-force tests.
- Errors clear only on reset.

Optional Feature:
- Macro WB_SCOREBOARD_BYPASS_EN.
- Defined: the source-hazard check treats a register as free when wb_valid=1, wb_nd matches it, and cnt==1. The stall is removed in the same cycle as the write-back, matching a register file with write-through read bypass.
- The destination-max check is unaffected.
- Undefined: hazard uses registered cnt only, giving one extra stall cycle.

Test Plan:
- Reset, then issue_valid=1, rs=3, rt=4, use_rt=1, we=1, nd=5 -> issue_ready=1, stall=0; next cycle busy_vec=0x20.
- With cnt[5]=1, issue rs=5 -> stall=1. wb_valid, wb_nd=5 -> next cycle stall=0, busy_vec[5]=0. With BYPASS_EN, stall=0 in the write-back cycle.
- Issue we=1, nd=7 three times (CNT_W=2) -> cnt[7]=3. A fourth issue to nd=7 stalls. Three write-backs to 7 -> busy_vec[7]=0, no errors.
- Accept issue nd=9 while wb_nd=9 in the same cycle with cnt[9]=0 -> cnt[9] stays 0, underflow_err=0.
- wb_valid, wb_nd=12 with cnt[12]=0 -> underflow_err=1 and stays 1. Issue nd=0 and rs=0 -> no stall, busy_vec[0]=0.
- Assert rst_n=0 asynchronously with cnt[2]=2 mid-cycle -> busy_vec=0 immediately. After release, wb_nd=2 -> underflow_err=1.
